// File: rtl/hex_scan_driver.sv
// Eight-digit multiplexed common-anode seven-segment scanner with per-frame snapshot and anode guard.
// Optional leading-zero blanking is enabled by defining HEX_LZ_BLANK_EN.
module hex_scan_driver #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] hex0,
   input  logic [31:0] hex1,
   input  logic [31:0] hex2,
   input  logic [31:0] hex3,
   input  logic [31:0] hex4,
   input  logic [31:0] hex5,
   input  logic [31:0] hex6,
   input  logic [31:0] hex7,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [7:0]  an_n,
   output logic        frame_done
);

   if (SCAN_DIV < BLANK_CYC + 2 || BLANK_CYC < 1) begin : g_param_check
      $error("hex_scan_driver: need SCAN_DIV >= BLANK_CYC+2 and BLANK_CYC >= 1");
   end

   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] BLANK_LAST = DW'(BLANK_CYC - 1);

   typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

   typedef struct packed {
      logic [6:0] raw_seg;
      logic       raw;
      logic       blank;
      logic       dp;
      logic [3:0] nib;
   } digit_t;

   function automatic logic [6:0] decode(input logic [3:0] nib);
      case (nib)
         4'h0: decode = 7'h3F;
         4'h1: decode = 7'h06;
         4'h2: decode = 7'h5B;
         4'h3: decode = 7'h4F;
         4'h4: decode = 7'h66;
         4'h5: decode = 7'h6D;
         4'h6: decode = 7'h7D;
         4'h7: decode = 7'h07;
         4'h8: decode = 7'h7F;
         4'h9: decode = 7'h6F;
         4'hA: decode = 7'h77;
         4'hB: decode = 7'h7C;
         4'hC: decode = 7'h39;
         4'hD: decode = 7'h5E;
         4'hE: decode = 7'h79;
         default: decode = 7'h71;
      endcase
   endfunction

   logic [31:0] w_hex [8];
   digit_t      w_dig_in [8];
   logic [7:0]  w_unused;

   assign w_hex = '{hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7};

   // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_dig_in[i] = '{raw_seg: w_hex[i][14:8], raw: w_hex[i][6], blank: w_hex[i][5],
                         dp: w_hex[i][4], nib: w_hex[i][3:0]};
         w_unused[i] = ^{w_hex[i][31:15], w_hex[i][7]};
      end
   end

   logic [DW-1:0] r_div_cnt;
   logic [2:0]    r_dig;
   state_t        r_state;
   digit_t        r_shadow [8];
   logic [6:0]    r_seg_n;
   logic          r_dp_n;
   logic [7:0]    r_an_n;
   logic          r_frame_done;

   logic          w_slot_end;
   logic          w_wrap;
   digit_t        w_cur;
   logic          w_lz_cur;
   logic [6:0]    w_seg_on;

   assign w_slot_end = (r_div_cnt == DIV_LAST);
   assign w_wrap     = w_slot_end && (r_dig == 3'd7);
   assign w_cur      = r_shadow[r_dig];
   assign w_seg_on   = w_cur.raw ? w_cur.raw_seg : decode(w_cur.nib);

`ifdef HEX_LZ_BLANK_EN
   logic [7:0] r_lz;
   logic [7:0] w_lz_next;
   logic       w_lz_run;

   // Leading zeros run from digit 7 downward; digit 0 always stays visible.
   always_comb begin
      w_lz_next = '0;
      w_lz_run  = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         w_lz_run     = w_lz_run & (w_dig_in[i].nib == 4'h0) & ~w_dig_in[i].raw & ~w_dig_in[i].dp;
         w_lz_next[i] = w_lz_run;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        r_lz <= '0;
      else if (w_wrap) r_lz <= w_lz_next;
   end

   assign w_lz_cur = r_lz[r_dig];
`else
   assign w_lz_cur = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div_cnt    <= '0;
         r_dig        <= '0;
         r_state      <= ST_BLANK;
         // NOTE: the shadow array is reset on purpose: the first frame after reset must show zeros.
         for (int i = 0; i < 8; i++) r_shadow[i] <= '0;
         r_seg_n      <= 7'h7F;
         r_dp_n       <= 1'b1;
         r_an_n       <= 8'hFF;
         r_frame_done <= 1'b0;
      end else begin
         if (w_slot_end) begin
            r_div_cnt <= '0;
            r_dig     <= r_dig + 3'd1;
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end

         case (r_state)
            ST_BLANK: if (r_div_cnt == BLANK_LAST) r_state <= ST_DRIVE;
            default:  if (w_slot_end)              r_state <= ST_BLANK;
         endcase

         if (w_wrap) begin
            for (int i = 0; i < 8; i++) r_shadow[i] <= w_dig_in[i];
         end
         r_frame_done <= w_wrap;

         if (r_state == ST_BLANK) begin
            r_an_n  <= 8'hFF;
            r_seg_n <= 7'h7F;
            r_dp_n  <= 1'b1;
         end else begin
            r_an_n <= ~(8'b1 << r_dig);
            if (w_cur.blank || w_lz_cur) begin
               r_seg_n <= 7'h7F;
               r_dp_n  <= 1'b1;
            end else begin
               r_seg_n <= ~w_seg_on;
               r_dp_n  <= ~w_cur.dp;
            end
         end
      end
   end

   assign seg_n      = r_seg_n;
   assign dp_n       = r_dp_n;
   assign an_n       = r_an_n;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with SCAN_DIV=8, BLANK_CYC=2 (64-cycle frame).
// Edge k after reset release shows the state left by edge k-1: slot ((k-1)/8)%8, offset (k-1)%8.
module tb_hex_scan_driver;
   localparam int SCAN_DIV  = 8;
   localparam int BLANK_CYC = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] hex [8];
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [7:0]  an_n;
   logic        frame_done;

   int cyc;
   int n_checks = 0;
   int n_errors = 0;

   hex_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) u_dut (
      .clk(clk), .rst(rst),
      .hex0(hex[0]), .hex1(hex[1]), .hex2(hex[2]), .hex3(hex[3]),
      .hex4(hex[4]), .hex5(hex[5]), .hex6(hex[6]), .hex7(hex[7]),
      .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Park on the falling edge that follows rising edge k.
   task automatic at(input int k);
      int guard = 0;
      while (cyc != k && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != k) check("at_timeout", 32'(cyc), 32'(k));
   endtask

   function automatic logic [6:0] exp_lz_seg(input int s);
`ifdef HEX_LZ_BLANK_EN
      if (s >= 3) return 7'h7F;
`endif
      if (s == 2) return 7'h24;
      return 7'h40;
   endfunction

   initial begin
      for (int i = 0; i < 8; i++) hex[i] = 32'h0;

      // Reset held
      repeat (3) @(negedge clk);
      check("rst_seg", 32'(seg_n), 32'h7F);
      check("rst_an", 32'(an_n), 32'hFF);
      check("rst_dp", 32'(dp_n), 32'h1);
      check("rst_fd", 32'(frame_done), 32'h0);

      rst = 1'b1;
      at(2);
      check("rel_an_k2", 32'(an_n), 32'hFF);
      at(3);
      check("rel_an_k3", 32'(an_n), 32'hFE);
      check("rel_seg_k3", 32'(seg_n), 32'h40);

      hex[0] = 32'h1;
      hex[1] = 32'h8;
      hex[2] = 32'hF;
      hex[3] = 32'h10;
      hex[4] = 32'h4940;
      hex[5] = 32'h25;

      at(63);
      check("fd_k63", 32'(frame_done), 32'h0);
      at(64);
      check("fd_k64", 32'(frame_done), 32'h1);
      at(65);
      check("fd_k65", 32'(frame_done), 32'h0);

      at(66);
      hex[0] = 32'h8;
      at(67);
      check("s0_seg", 32'(seg_n), 32'h79);
      check("s0_dp", 32'(dp_n), 32'h1);
      check("s0_an", 32'(an_n), 32'hFE);
      at(72);
      check("s0_seg_hold", 32'(seg_n), 32'h79);
      at(75);
      check("s1_seg", 32'(seg_n), 32'h00);
      at(83);
      check("s2_seg", 32'(seg_n), 32'h0E);
      at(91);
      check("s3_seg", 32'(seg_n), 32'h40);
      check("s3_dp", 32'(dp_n), 32'h0);
      check("s3_an", 32'(an_n), 32'hF7);
      at(99);
      check("s4_raw_seg", 32'(seg_n), 32'h36);
      at(107);
      check("s5_blank_seg", 32'(seg_n), 32'h7F);
      check("s5_blank_an", 32'(an_n), 32'hDF);
      check("s5_blank_dp", 32'(dp_n), 32'h1);

      for (int k = 113; k <= 120; k++) begin
         at(k);
         check($sformatf("guard_s6_k%0d", k), 32'(an_n), (k - 113 < 2) ? 32'hFF : 32'hBF);
      end

      at(131);
      check("snap_s0_seg", 32'(seg_n), 32'h00);

      for (int i = 0; i < 8; i++) hex[i] = 32'h0;
      hex[2] = 32'h2;

      for (int k = 132; k <= 192; k++) begin
         logic [7:0] exp_an;
         at(k);
         exp_an = ((k - 1) % 8 < 2) ? 8'hFF : ~(8'h01 << (((k - 1) / 8) % 8));
         check($sformatf("scan_an_k%0d", k), 32'(an_n), 32'(exp_an));
         check($sformatf("scan_fd_k%0d", k), 32'(frame_done), (k % 64 == 0) ? 32'h1 : 32'h0);
      end

      for (int s = 0; s < 8; s++) begin
         at(195 + 8 * s);
         check($sformatf("lz_seg_s%0d", s), 32'(seg_n), 32'(exp_lz_seg(s)));
         if (s == 4) begin
            at(228);
            check("mid_an_before", 32'(an_n), 32'hEF);
            @(posedge clk);
            #2 rst = 1'b0;
            #1;
            check("mid_rst_an", 32'(an_n), 32'hFF);
            check("mid_rst_seg", 32'(seg_n), 32'h7F);
            check("mid_rst_fd", 32'(frame_done), 32'h0);
            break;
         end
      end

      @(negedge clk);
      rst = 1'b1;
      at(2);
      check("restart_an_k2", 32'(an_n), 32'hFF);
      at(3);
      check("restart_an_k3", 32'(an_n), 32'hFE);
      check("restart_seg_k3", 32'(seg_n), 32'h40);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
